mdu: RTL

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It executes mult, multu, div and divu over a fixed multi-cycle latency and holds the architectural HI/LO registers. It also serves mthi, mtlo, mfhi and mflo. It drives the busy signal that the hazard/stall unit consumes as `E_MDU_busy` to hold HI/LO-related instructions in D.

---
 rtl/mdu.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: fixed-latency mult/multu/div/divu
// with architectural HI/LO, plus the mthi/mtlo/mfhi/mflo moves.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [31:0] hi_reg, lo_reg;
    logic [31:0] pend_hi_reg, pend_lo_reg;
    logic        pend_skip_reg;
    logic        busy_reg;
    logic [3:0]  count_reg;

    logic        is_mul, is_div, start;
    logic [63:0] mul_a, mul_b, product;
    logic        div_signed, a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_safe, uquot, urem, quot, rem;
    logic [31:0] pend_hi_next, pend_lo_next;
    logic        pend_skip_next;
    logic [3:0]  count_next;

    assign is_mul = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU);
    assign is_div = (MDU_op == OP_DIV)  || (MDU_op == OP_DIVU);
    assign start  = (is_mul || is_div) && !busy_reg;
    // Combinational in the start cycle so a dependent instruction in D stalls now.
    assign busy   = start || busy_reg;

    // Sign/zero extension to 64 bits lets one multiplier serve both flavours.
    assign mul_a   = {(MDU_op == OP_MULT) ? {32{A[31]}} : 32'd0, A};
    assign mul_b   = {(MDU_op == OP_MULT) ? {32{B[31]}} : 32'd0, B};
    assign product = mul_a * mul_b;

    // Signed divide via magnitudes; this also yields 0x80000000/-1 = 0x80000000.
    assign div_signed = (MDU_op == OP_DIV);
    assign a_neg      = div_signed && A[31];
    assign b_neg      = div_signed && B[31];
    assign a_mag      = a_neg ? (32'd0 - A) : A;
    assign b_mag      = b_neg ? (32'd0 - B) : B;
    assign div_zero   = (B == 32'd0);
    assign b_safe     = div_zero ? 32'd1 : b_mag;
    assign uquot      = a_mag / b_safe;
    assign urem       = a_mag % b_safe;
    assign quot       = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
    assign rem        = a_neg ? (32'd0 - urem) : urem;

    always_comb begin
        pend_hi_next   = rem;
        pend_lo_next   = quot;
        pend_skip_next = div_zero;
        count_next     = DIV_LOAD;
        if (is_mul) begin
            pend_hi_next   = product[63:32];
            pend_lo_next   = product[31:0];
            pend_skip_next = 1'b0;
            count_next     = MULT_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
            pend_hi_reg   <= 32'd0;
            pend_lo_reg   <= 32'd0;
            pend_skip_reg <= 1'b0;
            busy_reg      <= 1'b0;
            count_reg     <= 4'd0;
        end else if (busy_reg) begin
            // New ops and moves are ignored while an operation is in flight.
            count_reg <= count_reg - 4'd1;
            if (count_reg == 4'd1) begin
                busy_reg  <= 1'b0;
                count_reg <= 4'd0;
                if (!pend_skip_reg) begin
                    hi_reg <= pend_hi_reg;
                    lo_reg <= pend_lo_reg;
                end
            end
        end else if (start) begin
            pend_hi_reg   <= pend_hi_next;
            pend_lo_reg   <= pend_lo_next;
            pend_skip_reg <= pend_skip_next;
            count_reg     <= count_next;
            busy_reg      <= 1'b1;
        end else if (MDU_op == OP_MTHI) begin
            hi_reg <= A;
        end else if (MDU_op == OP_MTLO) begin
            lo_reg <= A;
        end
    end

    assign HI = hi_reg;
    assign LO = lo_reg;

    always_comb begin
        MDU_out = 32'd0;
        if (MDU_op == OP_MFHI)
            MDU_out = hi_reg;
        else if (MDU_op == OP_MFLO)
            MDU_out = lo_reg;
    end

endmodule
